idelay_tap_ctrl: RTL and testbench

IDELAY_TAP_CTRL -- requirements
Module: idelay_tap_ctrl

---
 rtl/ddr3_idelay_pkg.sv | 21 ++
 rtl/idelay_settle_cnt.sv | 27 ++
 rtl/idelay_tap_ctrl.sv | 106 ++++++++++
 tb/tb_idelay_tap_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_idelay_pkg.sv
// ddr3_idelay_pkg: shared op/state encodings and tap-range constants for the IDELAY tap controller
package ddr3_idelay_pkg;

   localparam int unsigned TAP_W = 5;
   localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_INIT = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_INIT   = 2'b00,
      ST_IDLE   = 2'b01,
      ST_APPLY  = 2'b10,
      ST_SETTLE = 2'b11
   } state_e;

endpackage

// File: rtl/idelay_settle_cnt.sv
// idelay_settle_cnt: down-counter that measures the settle window after a tap change
module idelay_settle_cnt #(
   parameter int unsigned CYCLES = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_count,
   output logic o_expire
);

   logic [7:0] cnt_q, cnt_d;

   // load with CYCLES-1 so expiry lands on the last of CYCLES counted cycles
   always_comb begin
      cnt_d = i_load ? 8'(CYCLES - 1) : (i_count && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
   end

   // counter register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) cnt_q <= 8'd0;
      else          cnt_q <= cnt_d;
   end

   assign o_expire = cnt_q == 8'd0;

endmodule

// File: rtl/idelay_tap_ctrl.sv
// idelay_tap_ctrl: drives IDELAYE2 LD/CE/INC to load or step the tap; IDELAY_TAP_CHECK_EN adds readback checking
module idelay_tap_ctrl
   import ddr3_idelay_pkg::*;
#(
   parameter int unsigned      SETTLE_CYCLES = 8,
   parameter logic [TAP_W-1:0] INIT_TAP      = 5'd0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req_valid,
   input  logic [1:0]       i_req_op,
   input  logic [TAP_W-1:0] i_req_tap,
   output logic             o_req_ready,
   output logic             o_ld,
   output logic             o_ce,
   output logic             o_inc,
   output logic [TAP_W-1:0] o_cntvaluein,
   input  logic [TAP_W-1:0] i_cntvalueout,
   output logic [TAP_W-1:0] o_tap,
   output logic             o_done,
   output logic             o_sat_err,
   output logic             o_mismatch
);

   state_e           state_q, state_d;
   op_e              op_q;
   logic [TAP_W-1:0] req_tap_q, tap_q, tap_d, cnt_q, target;
   logic             run_q, sat, load_op, apply_ok, expire, settle_load;

   // primitive drive and tap bookkeeping; run_q keeps LD low while reset is still held
   always_comb begin
      sat          = (op_q == OP_INC && tap_q == TAP_MAX) || (op_q == OP_DEC && tap_q == '0);
      load_op      = op_q == OP_LOAD || op_q == OP_INIT;
      target       = (state_q == ST_INIT || op_q == OP_INIT) ? INIT_TAP : req_tap_q;
      apply_ok     = state_q == ST_APPLY && !sat;
      o_ld         = (state_q == ST_INIT && run_q) || (apply_ok && load_op);
      o_ce         = apply_ok && !load_op;
      o_inc        = o_ce && op_q == OP_INC;
      o_cntvaluein = o_ld ? target : cnt_q;
      tap_d        = o_ld ? target : o_ce ? (o_inc ? tap_q + 1'b1 : tap_q - 1'b1) : tap_q;
      o_req_ready  = state_q == ST_IDLE;
      o_sat_err    = state_q == ST_APPLY && sat;
      o_done       = (state_q == ST_SETTLE && expire) || o_sat_err;
   end

   // next-state logic; saturated requests skip the settle window
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:   state_d = run_q ? ST_SETTLE : ST_INIT;
         ST_IDLE:   state_d = i_req_valid ? ST_APPLY : ST_IDLE;
         ST_APPLY:  state_d = sat ? ST_IDLE : ST_SETTLE;
         ST_SETTLE: state_d = expire ? ST_IDLE : ST_SETTLE;
         default:   state_d = ST_INIT;
      endcase
      settle_load = state_d == ST_SETTLE && state_q != ST_SETTLE;
   end

   // state, tracked tap, held CNTVALUEIN and latched request
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_INIT;
         run_q     <= 1'b0;
         op_q      <= OP_LOAD;
         req_tap_q <= '0;
         tap_q     <= INIT_TAP;
         cnt_q     <= INIT_TAP;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         tap_q   <= tap_d;
         if (o_ld) cnt_q <= o_cntvaluein;
         if (o_req_ready && i_req_valid) begin
            op_q      <= op_e'(i_req_op);
            req_tap_q <= i_req_tap;
         end
      end
   end

   idelay_settle_cnt #(.CYCLES(SETTLE_CYCLES)) u_settle (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (settle_load),
      .i_count  (state_q == ST_SETTLE),
      .o_expire (expire)
   );

   assign o_tap = tap_q;

`ifdef IDELAY_TAP_CHECK_EN
   logic mismatch_q;

   // sticky flag: any IDLE-cycle disagreement between primitive and tracked tap
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) mismatch_q <= 1'b0;
      else if (state_q == ST_IDLE && i_cntvalueout != tap_q) mismatch_q <= 1'b1;
   end

   assign o_mismatch = mismatch_q;
`else
   logic unused_cntvalueout;
   assign unused_cntvalueout = ^i_cntvalueout;
   assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// tb_idelay_tap_ctrl: vector table, directed corner sequences and randomized requests vs a tap model
module tb_idelay_tap_ctrl;
   localparam int S = 8;
   localparam logic [4:0] IT = 5'd5;
`ifdef IDELAY_TAP_CHECK_EN
   localparam int CHK_EN = 1;
`else
   localparam int CHK_EN = 0;
`endif

   typedef struct {
      logic [1:0] op;
      logic [4:0] tap;
      int         etap;
      bit         esat;
   } vec_t;

   logic clk = 0, rst_n = 0, valid = 0, force_en = 0;
   logic [1:0] op = 0;
   logic [4:0] rtap = 0, cvi, cvo, tap, prim = 0, fval = 0;
   logic ready, ld, ce, inc, done, sat, mism;
   int checks = 0, failures = 0;
   vec_t tbl[10];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld) prim <= cvi;
      else if (ce) prim <= inc ? prim + 5'd1 : prim - 5'd1;
   end

   assign cvo = force_en ? fval : prim;

   idelay_tap_ctrl #(.SETTLE_CYCLES(S), .INIT_TAP(IT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_op(op), .i_req_tap(rtap),
      .o_req_ready(ready), .o_ld(ld), .o_ce(ce), .o_inc(inc), .o_cntvaluein(cvi),
      .i_cntvalueout(cvo), .o_tap(tap), .o_done(done), .o_sat_err(sat), .o_mismatch(mism)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int nxt(input int cur, input int o, input int t);
      return o == 0 ? t : o == 3 ? int'(IT) : o == 1 ? (cur == 31 ? cur : cur + 1) : (cur == 0 ? 0 : cur - 1);
   endfunction

   function automatic bit is_sat(input int cur, input int o);
      return (o == 1 && cur == 31) || (o == 2 && cur == 0);
   endfunction

   task automatic wait_done(output int dk, output int nrdy);
      dk = -1;
      nrdy = 0;
      for (int k = 1; k <= 40; k++) begin
         if (ready) nrdy++;
         if (done) begin
            dk = k;
            break;
         end
         tick;
      end
   endtask

   task automatic do_req(input logic [1:0] o, input logic [4:0] t, input int etap, input bit esat);
      int dk = -1, nld = 0, nce = 0, ninc = 0, nsat = 0, nboth = 0, ldk = -1;
      bit isload, isstep;
      isload = !esat && (o == 2'd0 || o == 2'd3);
      isstep = !esat && (o == 2'd1 || o == 2'd2);
      chk("ready_before_req", ready, 1);
      valid = 1; op = o; rtap = t;
      tick;
      valid = 0;
      for (int k = 1; k <= 40; k++) begin
         if (ld) begin nld++; ldk = k; end
         if (ce) nce++;
         if (ce && inc) ninc++;
         if (ld && ce) nboth++;
         if (sat) nsat++;
         if (done) begin
            dk = k;
            break;
         end
         tick;
      end
      chk("done_latency", dk, esat ? 1 : 1 + S);
      chk("ld_pulses", nld, int'(isload));
      if (isload) chk("ld_cycle", ldk, 1);
      chk("ce_pulses", nce, int'(isstep));
      chk("inc_pulses", ninc, int'(isstep && o == 2'd1));
      chk("ld_ce_overlap", nboth, 0);
      chk("sat_err_pulses", nsat, int'(esat));
      tick;
      chk("tap_after", tap, etap);
      chk("primitive_readback", prim, etap);
      chk("ready_after", ready, 1);
      chk("mismatch_clean", mism, 0);
   endtask

   task automatic release_and_init;
      int dk = -1, nld = 0;
      rst_n = 1;
      tick;
      chk("init_ld", ld, 1);
      chk("init_cntvaluein", cvi, IT);
      chk("init_tap", tap, IT);
      chk("init_ready_low", ready, 0);
      for (int k = 1; k <= 40; k++) begin
         tick;
         if (ld) nld++;
         if (done) begin
            dk = k;
            break;
         end
      end
      chk("init_done_latency", dk, S);
      chk("init_extra_ld", nld, 0);
      tick;
      chk("init_ready", ready, 1);
      chk("init_readback", prim, IT);
   endtask

   task automatic reset_checks;
      chk("rst_ld", ld, 0);
      chk("rst_ce", ce, 0);
      chk("rst_inc", inc, 0);
      chk("rst_done", done, 0);
      chk("rst_sat_err", sat, 0);
      chk("rst_ready", ready, 0);
      chk("rst_tap", tap, IT);
      chk("rst_cntvaluein", cvi, IT);
      chk("rst_mismatch", mism, 0);
   endtask

   initial begin
      int dk, nrdy, nd, cur, o, t, e;
      tbl[0] = '{2'd0, 5'd17, 17, 1'b0};
      tbl[1] = '{2'd0, 5'd30, 30, 1'b0};
      tbl[2] = '{2'd1, 5'd0,  31, 1'b0};
      tbl[3] = '{2'd1, 5'd0,  31, 1'b1};
      tbl[4] = '{2'd0, 5'd0,  0,  1'b0};
      tbl[5] = '{2'd2, 5'd9,  0,  1'b1};
      tbl[6] = '{2'd1, 5'd9,  1,  1'b0};
      tbl[7] = '{2'd2, 5'd0,  0,  1'b0};
      tbl[8] = '{2'd3, 5'd22, 5,  1'b0};
      tbl[9] = '{2'd2, 5'd0,  4,  1'b0};

      rst_n = 0;
      tick; tick;
      reset_checks();
      release_and_init();

      foreach (tbl[i]) do_req(tbl[i].op, tbl[i].tap, tbl[i].etap, tbl[i].esat);

      valid = 1; op = 2'd0; rtap = 5'd9;
      tick;
      rtap = 5'd20;
      wait_done(dk, nrdy);
      chk("held_done_latency", dk, 1 + S);
      chk("held_ready_in_settle", nrdy, 0);
      tick;
      chk("held_ready_idle", ready, 1);
      chk("held_tap_first", tap, 9);
      tick;
      valid = 0;
      wait_done(dk, nrdy);
      chk("held_second_latency", dk, 1 + S);
      tick;
      chk("held_tap_second", tap, 20);

      valid = 1; op = 2'd0; rtap = 5'd12;
      tick;
      valid = 0;
      tick; tick; tick;
      rst_n = 0;
      nd = 0;
      for (int k = 0; k < 3; k++) begin
         tick;
         if (done) nd++;
      end
      chk("abort_no_done", nd, 0);
      reset_checks();
      release_and_init();

      cur = IT;
      for (int n = 0; n < 40; n++) begin
         o = $urandom_range(0, 3);
         t = $urandom_range(0, 1) ? ($urandom_range(0, 1) ? 31 : 0) : $urandom_range(0, 31);
         e = nxt(cur, o, t);
         do_req(o[1:0], t[4:0], e, is_sat(cur, o));
         cur = e;
      end

      do_req(2'd0, 5'd4, 4, 1'b0);
      fval = 5'd3;
      force_en = 1;
      tick; tick;
      chk("mismatch_set", mism, CHK_EN);
      force_en = 0;
      tick; tick; tick;
      chk("mismatch_sticky", mism, CHK_EN);
      rst_n = 0;
      tick;
      chk("mismatch_cleared", mism, 0);
      release_and_init();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
